// File: rtl/fifod2mac.sv
// Transmit bridge from the ADC data FIFO to the MAC UDP payload port.
// Latches a frame length, requests a UDP send, streams FIFO bytes per MAC strobe, reports done.
module fifod2mac #(
  parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs,
  output logic        fd,
  output logic        err,
  input  logic [11:0] eth_tx_len,
  output logic        fifod_rxen,
  input  logic [7:0]  fifod_rxd,
  input  logic        fifod_empty,
  output logic        fs_udp_tx,
  input  logic        fd_udp_tx,
  output logic [11:0] udp_tx_len,
  input  logic        flag_udp_tx_req,
  input  logic        udp_txen,
  output logic [7:0]  udp_txd,
  output logic [2:0]  dbg_state_o
);

  // Handshake: fs/fd are levels. The requester holds fs until it sees fd; fd stays
  // high until fs drops. fs_udp_tx/fd_udp_tx towards the MAC follow the same rule.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_SEND, S_WAIT, S_DONE
  } state_t;

  state_t      state_q;
  logic [11:0] len_q;
  logic [11:0] cnt_q;
  logic [23:0] wdog_q;
  logic        rd_q;
  logic        fd_q;
  logic        err_q;
  logic        fs_udp_tx_q;

  logic slot;
  logic underrun;
  logic wdog_exp;

  // A byte slot is every strobe in SEND until the frame length is consumed.
  assign slot       = (state_q == S_SEND) && udp_txen && (cnt_q < len_q);
  assign fifod_rxen = slot && !fifod_empty;
  assign underrun   = slot && fifod_empty;
  assign wdog_exp   = (wdog_q == (TIMEOUT - 24'd1));

  assign udp_txd     = rd_q ? fifod_rxd : 8'h00;
  assign fd          = fd_q;
  assign err         = err_q;
  assign fs_udp_tx   = fs_udp_tx_q;
  assign udp_tx_len  = len_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= 12'd0;
      cnt_q       <= 12'd0;
      wdog_q      <= 24'd0;
      rd_q        <= 1'b0;
      fd_q        <= 1'b0;
      err_q       <= 1'b0;
      fs_udp_tx_q <= 1'b0;
    end else begin
      rd_q <= fifod_rxen;
      case (state_q)
        S_IDLE: begin
          if (fs) begin
            state_q <= S_LOAD;
            len_q   <= eth_tx_len;
            err_q   <= 1'b0;
            cnt_q   <= 12'd0;
            wdog_q  <= 24'd0;
          end
        end
        S_LOAD: begin
          wdog_q <= 24'd0;
          if (len_q == 12'd0) begin
            state_q <= S_DONE;
            fd_q    <= 1'b1;
          end else begin
            state_q     <= S_REQ;
            fs_udp_tx_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (flag_udp_tx_req) begin
            state_q <= S_SEND;
            wdog_q  <= 24'd0;
          end else if (wdog_exp) begin
            state_q     <= S_DONE;
            wdog_q      <= 24'd0;
            fd_q        <= 1'b1;
            err_q       <= 1'b1;
            fs_udp_tx_q <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 24'd1;
          end
        end
        S_SEND: begin
          if (slot) begin
            cnt_q <= cnt_q + 12'd1;
            // An empty FIFO still consumes the slot so the MAC frame length holds.
            if (underrun) err_q <= 1'b1;
            if ((cnt_q + 12'd1) == len_q) begin
              state_q <= S_WAIT;
              wdog_q  <= 24'd0;
            end
          end
        end
        S_WAIT: begin
          if (fd_udp_tx) begin
            state_q     <= S_DONE;
            wdog_q      <= 24'd0;
            fd_q        <= 1'b1;
            fs_udp_tx_q <= 1'b0;
          end else if (wdog_exp) begin
            state_q     <= S_DONE;
            wdog_q      <= 24'd0;
            fd_q        <= 1'b1;
            err_q       <= 1'b1;
            fs_udp_tx_q <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 24'd1;
          end
        end
        S_DONE: begin
          if (!fs) begin
            state_q <= S_IDLE;
            fd_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          fd_q        <= 1'b0;
          fs_udp_tx_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifod2mac.sv
// Bench for fifod2mac: FIFO and MAC models, per-cycle byte scoreboard, directed transfers.
module tb_fifod2mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs = 1'b0;
  logic        fd;
  logic        err;
  logic [11:0] eth_tx_len = 12'd0;
  logic        fifod_rxen;
  logic [7:0]  fifod_rxd = 8'h00;
  logic        fifod_empty;
  logic        fs_udp_tx;
  logic        fd_udp_tx = 1'b0;
  logic [11:0] udp_tx_len;
  logic        flag_udp_tx_req = 1'b0;
  logic        udp_txen = 1'b0;
  logic [7:0]  udp_txd;
  logic [2:0]  dbg_state;

  fifod2mac #(.TIMEOUT(24'd100)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fs              (fs),
    .fd              (fd),
    .err             (err),
    .eth_tx_len      (eth_tx_len),
    .fifod_rxen      (fifod_rxen),
    .fifod_rxd       (fifod_rxd),
    .fifod_empty     (fifod_empty),
    .fs_udp_tx       (fs_udp_tx),
    .fd_udp_tx       (fd_udp_tx),
    .udp_tx_len      (udp_tx_len),
    .flag_udp_tx_req (flag_udp_tx_req),
    .udp_txen        (udp_txen),
    .udp_txd         (udp_txd),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model (1-cycle read latency) ----------------
  logic [7:0] fifo_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush = 1'b0;
  int         rd_pulses = 0;

  assign fifod_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifod_rxen) begin
      fifod_rxd <= fifo_mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
    if (rst_n && fifod_rxen) rd_pulses <= rd_pulses + 1;
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic       chk_en = 1'b0;
  logic [8:0] exp_q[$];   // {fifod_rxen, udp_txd} expected per cycle
  logic [7:0] ref_q[$];   // bytes the FIFO should hand out, in order
  logic [7:0] cap_q[$];   // bytes the MAC model captured

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [8:0] e;
    if (chk_en) begin
      e = 9'd0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("rxen_cycle", {31'd0, fifod_rxen}, {31'd0, e[8]});
      check("txd_cycle", {24'd0, udp_txd}, {24'd0, e[7:0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_fifo(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr % 256] = base + 8'(i);
      wr_ptr = wr_ptr + 1;
      ref_q.push_back(base + 8'(i));
    end
  endtask

  // fs sampled at edge t; REQ (or DONE for zero length) is entered at edge t+1.
  task automatic start_xfer(input int len);
    fs = 1'b1;
    eth_tx_len = 12'(len);
    tick;
    tick;
    check("udp_tx_len", {20'd0, udp_tx_len}, len);
    check("fs_udp_tx_start", {31'd0, fs_udp_tx}, {31'd0, (len != 0)});
    check("fd_start", {31'd0, fd}, {31'd0, (len == 0)});
    check("err_start", {31'd0, err}, 32'd0);
  endtask

  // MAC model: raise flag, then strobe (continuous or every other cycle) up to max_s bytes.
  task automatic mac_send(input int len, input int max_s, input bit gap);
    logic [7:0] pending;
    logic       prev_txen;
    logic       erx;
    int         n;
    int         cyc;
    pending = 8'h00;
    prev_txen = 1'b0;
    n = 0;
    cyc = 0;
    cap_q.delete();
    flag_udp_tx_req = 1'b1;
    tick;
    while (n < max_s && cyc < 1000) begin
      if (prev_txen) cap_q.push_back(udp_txd);
      udp_txen = gap ? ((cyc % 2) == 0) : 1'b1;
      erx = udp_txen && (n < len) && (ref_q.size() > 0);
      exp_q.push_back({erx, pending});
      pending = erx ? ref_q.pop_front() : 8'h00;
      if (udp_txen && n < len) n++;
      prev_txen = udp_txen;
      cyc++;
      tick;
    end
    if (prev_txen) cap_q.push_back(udp_txd);
    udp_txen = 1'b0;
    exp_q.push_back({1'b0, pending});
    tick;
    check("strobe_budget", cyc < 1000, 32'd1);
  endtask

  task automatic mac_done;
    fd_udp_tx = 1'b1;
    tick;
    fd_udp_tx = 1'b0;
    flag_udp_tx_req = 1'b0;
    check("fd_after_mac_done", {31'd0, fd}, 32'd1);
    check("fs_udp_tx_after_done", {31'd0, fs_udp_tx}, 32'd0);
  endtask

  task automatic end_xfer;
    fs = 1'b0;
    tick;
    check("fd_release", {31'd0, fd}, 32'd0);
  endtask

  task automatic cap_at(input string nm, input int idx, input logic [7:0] exp);
    if (idx < cap_q.size()) check(nm, {24'd0, cap_q[idx]}, {24'd0, exp});
    else check(nm, 32'hDEAD, {24'd0, exp});
  endtask

  // ---------------- global bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    int n;

    // Reset state
    tick;
    tick;
    check("rst_fd", {31'd0, fd}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_fs_udp_tx", {31'd0, fs_udp_tx}, 32'd0);
    check("rst_udp_tx_len", {20'd0, udp_tx_len}, 32'd0);
    check("rst_udp_txd", {24'd0, udp_txd}, 32'd0);
    check("rst_rxen", {31'd0, fifod_rxen}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick;

    // Nominal 64-byte frame, continuous strobe
    load_fifo(64, 8'h00);
    p0 = rd_pulses;
    start_xfer(64);
    mac_send(64, 64, 1'b0);
    check("nom_cap_size", cap_q.size(), 32'd64);
    cap_at("nom_byte0", 0, 8'h00);
    cap_at("nom_byte63", 63, 8'h3F);
    check("nom_rd_pulses", rd_pulses - p0, 32'd64);
    check("nom_err", {31'd0, err}, 32'd0);
    mac_done;
    end_xfer;
    check("nom_fifo_empty", {31'd0, fifod_empty}, 32'd1);

    // Gapped strobe
    load_fifo(64, 8'h00);
    start_xfer(64);
    mac_send(64, 64, 1'b1);
    check("gap_cap_size", cap_q.size(), 32'd64);
    cap_at("gap_byte1", 1, 8'h01);
    cap_at("gap_byte32", 32, 8'h20);
    mac_done;
    check("gap_err", {31'd0, err}, 32'd0);
    end_xfer;
    check("gap_fifo_empty", {31'd0, fifod_empty}, 32'd1);

    // Zero length: done at t+2, no MAC request, no reads
    p0 = rd_pulses;
    start_xfer(0);
    tick;
    check("zero_fd_held", {31'd0, fd}, 32'd1);
    check("zero_fs_udp_tx", {31'd0, fs_udp_tx}, 32'd0);
    end_xfer;
    check("zero_rd_pulses", rd_pulses - p0, 32'd0);
    check("zero_err", {31'd0, err}, 32'd0);

    // Underrun: 10 bytes available, 16 requested
    load_fifo(10, 8'h00);
    start_xfer(16);
    mac_send(16, 16, 1'b0);
    cap_at("urun_byte9", 9, 8'h09);
    cap_at("urun_byte10", 10, 8'h00);
    cap_at("urun_byte15", 15, 8'h00);
    check("urun_err", {31'd0, err}, 32'd1);
    mac_done;
    end_xfer;
    check("urun_err_sticky", {31'd0, err}, 32'd1);

    // Timeout in REQ (TIMEOUT=100); start_xfer also sees err cleared
    start_xfer(8);
    n = 0;
    while (!fd && n < 300) begin
      tick;
      n++;
    end
    check("tmo_cycles", n, 32'd100);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_fs_udp_tx", {31'd0, fs_udp_tx}, 32'd0);
    end_xfer;

    // Reset mid-SEND after 20 of 64 bytes
    load_fifo(64, 8'h40);
    start_xfer(64);
    mac_send(64, 20, 1'b0);
    cap_at("mid_byte19", 19, 8'h53);
    rst_n = 1'b0;
    fs = 1'b0;
    flag_udp_tx_req = 1'b0;
    tick;
    check("mid_rst_fd", {31'd0, fd}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_fs_udp_tx", {31'd0, fs_udp_tx}, 32'd0);
    check("mid_rst_udp_tx_len", {20'd0, udp_tx_len}, 32'd0);
    check("mid_rst_udp_txd", {24'd0, udp_txd}, 32'd0);
    rst_n = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    ref_q.delete();
    check("mid_flushed", {31'd0, fifod_empty}, 32'd1);

    load_fifo(8, 8'hC0);
    start_xfer(8);
    mac_send(8, 8, 1'b0);
    check("post_cap_size", cap_q.size(), 32'd8);
    cap_at("post_byte0", 0, 8'hC0);
    cap_at("post_byte7", 7, 8'hC7);
    mac_done;
    check("post_err", {31'd0, err}, 32'd0);
    end_xfer;

    tick;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifod2mac.md
# fifod2mac

Transmit-side bridge between the ADC data FIFO (fifod) and the UDP transmit port of the MAC. When the control sequencer starts a transfer, it latches the frame length, requests a UDP transmission, and feeds FIFO bytes to the MAC as the MAC pulls them. It then reports completion back to the sequencer. It runs in the gmii_txc domain, after adc2fifod and before mac, and uses the same fs/fd level handshake as the other stages.

## Interface
- TIMEOUT, 24'd1_000_000: cycles allowed in REQ or WAIT before the transfer is aborted.
- clk  in  1  gmii_txc; single clock for the block.
- rst_n  in  1  synchronous reset, active-low.
- fs  in  1  start level from cs; held until fd seen.
- fd  out  1  done level to cs.
- err  out  1  sticky error for the current transfer; cleared on the next accepted fs.
- eth_tx_len  in  12  payload byte count; sampled on the IDLE→LOAD transition.
- fifod_rxen  out  1  FIFO read enable.
- fifod_rxd  in  8  FIFO read data, valid 1 cycle after fifod_rxen.
- fifod_empty  in  1  FIFO empty flag.
- fs_udp_tx  out  1  UDP transmit start level to the MAC.
- fd_udp_tx  in  1  UDP transmit done level from the MAC.
- udp_tx_len  out  12  latched payload length to the MAC.
- flag_udp_tx_req  in  1  MAC ready for payload (header sent).
- udp_txen  in  1  MAC byte strobe; one payload byte per high cycle.
- udp_txd  out  8  payload byte to the MAC.

## Operation
- States: IDLE, LOAD, REQ, SEND, WAIT, DONE.
- IDLE: on fs=1 go to LOAD; clear err, cnt, wdog.
- LOAD: latch len=eth_tx_len into udp_tx_len.
  - len==0 → DONE; no FIFO read; fs_udp_tx never asserted.
  - otherwise → REQ.
- REQ: fs_udp_tx=1.
  - flag_udp_tx_req=1 → SEND.
  - wdog reaches TIMEOUT-1 → DONE with err=1.
- SEND: fs_udp_tx=1. Each cycle with udp_txen=1 increments cnt (12-bit, saturating at len).
  - cnt reaching len → WAIT.
- WAIT: fs_udp_tx=1 until fd_udp_tx=1, then fs_udp_tx=0 → DONE.
  - On TIMEOUT → DONE with err=1.
- DONE: fd=1, fs_udp_tx=0. When fs=0 → IDLE; fd=0 from the next cycle.
- fifod_rxen = (state==SEND) & udp_txen & (cnt<len) & ~fifod_empty. This is combinational.
- rd_d1 is the registered copy of fifod_rxen.
  - udp_txd = rd_d1 ? fifod_rxd : 8'h00.
- Underrun: udp_txen=1 in SEND while fifod_empty=1.
  - No read; the byte slot is still counted.
  - udp_txd=8'h00 next cycle; err=1.
- Overrun: udp_txen=1 outside SEND, or after cnt==len.
  - Ignored: no read, udp_txd=8'h00, no error.
- wdog: 24-bit counter, reset on every state change; counts only in REQ and WAIT.
- fs dropping mid-transfer is ignored; the transfer completes, then DONE sees fs=0 and returns to IDLE after one cycle of fd.
- Reset (rst_n=0 at a clock edge), from any state:
  - next state IDLE.
  - outputs fd=0, err=0, fifod_rxen=0, fs_udp_tx=0, udp_tx_len=0, udp_txd=8'h00.
  - rd_d1, cnt and wdog cleared.
  - A partial frame is abandoned; FIFO contents are left for cs to flush through rst_fifod.

## Timing
- fs high at edge t → LOAD at t+1, REQ at t+2, so fs_udp_tx=1 from cycle t+2.
- Byte latency: udp_txen at cycle k → udp_txd valid at cycle k+1. The MAC samples data one cycle after its strobe.
- Back-to-back udp_txen sustains 1 byte/cycle; no bubbles are inserted.
- The last strobe (cnt len-1→len) moves the state to WAIT on the next edge. The final byte is still presented at k+1.
- fd_udp_tx seen at edge w → fs_udp_tx=0 and fd=1 from w+1.
- Minimum turnaround: fd rises, fs falls, fd falls 1 cycle later, and a new fs is accepted the cycle after that.

## Test plan
- Nominal: FIFO preloaded 0x00..0x3F, eth_tx_len=64, MAC model gives continuous udp_txen after flag_udp_tx_req → 64 bytes 0x00..0x3F in order; udp_tx_len=64; exactly 64 fifod_rxen pulses; fd=1; err=0.
- Gapped strobe: same data with udp_txen toggling 1/0 → identical byte stream with every byte at k+1; FIFO empty at end.
- Zero length: eth_tx_len=0 → fd=1 at cycle t+2; fs_udp_tx, fifod_rxen and err remain 0 throughout.
- Underrun: FIFO holds 10 bytes, eth_tx_len=16 → bytes 0..9 correct, then six 0x00 bytes; err=1 sticky until the next fs.
- Timeout: TIMEOUT=100, flag_udp_tx_req held 0 → fd=1 and err=1 at 100 cycles after REQ entry; fs_udp_tx drops.
- Reset mid-SEND after 20 of 64 bytes → all outputs take reset values at the next edge; a following 8-byte transfer completes cleanly.
